// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: drives a 32-bit combinational ALU (AND/OR/ADD, Binvert, CarryIn)
// to run narrow (DW) or wide (2*DW) AND/OR/ADD/SUB requests. Wide ops take two
// ALU passes, low word first, with the carry chained into the high pass.
// One request in flight; request and response use valid/ready handshakes.
module alu_seq_ctrl #(
  parameter int DW = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [2*DW-1:0]   req_a,
  input  logic [2*DW-1:0]   req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [2*DW-1:0]   rsp_result,
  output logic              rsp_carry,
  output logic [DW-1:0]     alu_a,
  output logic [DW-1:0]     alu_b,
  output logic [1:0]        alu_operation,
  output logic              alu_binvert,
  output logic              alu_carryin,
  input  logic [DW-1:0]     alu_result,
  input  logic              alu_carryout
);

  localparam logic [1:0] F_AND = 2'b00;
  localparam logic [1:0] F_OR  = 2'b01;
  localparam logic [1:0] F_ADD = 2'b10;
  localparam logic [1:0] F_SUB = 2'b11;

  localparam logic [1:0] ALU_AND = 2'b00;
  localparam logic [1:0] ALU_OR  = 2'b01;
  localparam logic [1:0] ALU_ADD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    RESP = 2'd3
  } state_t;

  // Latched request: op[2] = wide, op[1:0] = func
  typedef struct packed {
    logic [2:0]      op;
    logic [2*DW-1:0] a;
    logic [2*DW-1:0] b;
  } req_t;

  state_t          state, state_nxt;
  req_t            req_q;
  logic [2*DW-1:0] res_q;
  logic            carry_q;      // carry out of the most recent pass, chains LO -> HI
  logic            rsp_carry_q;  // reported carry, zero for logic ops

  logic [1:0]      func;
  logic            wide;
  logic            is_sub;
  logic            is_arith;
  logic            accept;

  assign func     = req_q.op[1:0];
  assign wide     = req_q.op[2];
  assign is_sub   = (func == F_SUB);
  assign is_arith = (func == F_ADD) || (func == F_SUB);

  assign req_ready  = (state == IDLE);
  assign accept     = req_valid && req_ready;
  assign rsp_valid  = (state == RESP);
  assign rsp_result = res_q;
  assign rsp_carry  = rsp_carry_q;

  // State register; reset aborts any in-flight op immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: narrow ops skip the HI pass
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept)    state_nxt = LO;
      LO:   state_nxt = wide ? HI : RESP;
      HI:   state_nxt = RESP;
      RESP: if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ALU drive: idle-zero outside the two compute passes so the ALU inputs stay quiet
  always_comb begin
    alu_a         = '0;
    alu_b         = '0;
    alu_operation = ALU_AND;
    alu_binvert   = 1'b0;
    alu_carryin   = 1'b0;
    if (state == LO || state == HI) begin
      case (func)
        F_AND:   alu_operation = ALU_AND;
        F_OR:    alu_operation = ALU_OR;
        default: alu_operation = ALU_ADD;
      endcase
      // SUB is A + ~B + 1: invert B, inject the +1 on the low pass only
      alu_binvert = is_sub;
      if (state == LO) begin
        alu_a       = req_q.a[DW-1:0];
        alu_b       = req_q.b[DW-1:0];
        alu_carryin = is_sub;
      end else begin
        alu_a       = req_q.a[2*DW-1:DW];
        alu_b       = req_q.b[2*DW-1:DW];
        alu_carryin = is_arith & carry_q;
      end
    end
  end

  // Request latch and result capture; result holds its value between requests
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q       <= '0;
      res_q       <= '0;
      carry_q     <= 1'b0;
      rsp_carry_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            req_q.op <= req_op;
            req_q.a  <= req_a;
            req_q.b  <= req_b;
          end
        end
        LO: begin
          res_q[DW-1:0] <= alu_result;
          carry_q       <= alu_carryout;
          if (!wide) begin
            res_q[2*DW-1:DW] <= '0;
            rsp_carry_q      <= is_arith & alu_carryout;
          end
        end
        HI: begin
          res_q[2*DW-1:DW] <= alu_result;
          carry_q          <= alu_carryout;
          rsp_carry_q      <= is_arith & alu_carryout;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: supplies a behavioural 32-bit ALU, drives directed and
// random requests, and checks responses through a scoreboard queue filled at
// accept time and drained by an independent monitor.
module tb_alu_seq_ctrl;
  localparam int DW = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid, req_ready, rsp_valid, rsp_ready, rsp_carry;
  logic [2:0]  req_op;
  logic [63:0] req_a, req_b, rsp_result;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [1:0]  alu_operation;
  logic        alu_binvert, alu_carryin, alu_carryout;

  always #5 clk = ~clk;

  alu_seq_ctrl #(.DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_carry(rsp_carry),
    .alu_a(alu_a), .alu_b(alu_b), .alu_operation(alu_operation),
    .alu_binvert(alu_binvert), .alu_carryin(alu_carryin),
    .alu_result(alu_result), .alu_carryout(alu_carryout)
  );

  // Behavioural ALU: carry out always comes from the adder, as in the real ALU
  logic [31:0] alu_bb;
  logic [32:0] alu_sum;
  always_comb begin
    alu_bb       = alu_binvert ? ~alu_b : alu_b;
    alu_sum      = {1'b0, alu_a} + {1'b0, alu_bb} + {32'b0, alu_carryin};
    alu_carryout = alu_sum[32];
    case (alu_operation)
      2'b00:   alu_result = alu_a & alu_bb;
      2'b01:   alu_result = alu_a | alu_bb;
      default: alu_result = alu_sum[31:0];
    endcase
  end

  typedef struct packed {
    logic [63:0] res;
    logic        c;
    logic [3:0]  lat;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          accept_cyc = 0;
  int          pass_idx = 0;
  logic        in_flight = 1'b0;
  logic        seen = 1'b0;
  logic        rand_bp = 1'b0;
  logic [2:0]  cur_op;
  logic [63:0] cur_a, cur_b;
  logic        lo_c;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: whole-operand arithmetic at the requested width
  function automatic exp_t ref_model(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    exp_t        e;
    logic [63:0] mask, ma, mb;
    logic [64:0] s;
    mask = op[2] ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    ma = a & mask;
    mb = b & mask;
    s  = {1'b0, ma} + {1'b0, mb};
    case (op[1:0])
      2'b00:   begin e.res = ma & mb; e.c = 1'b0; end
      2'b01:   begin e.res = ma | mb; e.c = 1'b0; end
      2'b10:   begin e.res = s[63:0] & mask; e.c = op[2] ? s[64] : s[32]; end
      default: begin e.res = (ma - mb) & mask; e.c = (ma >= mb); end
    endcase
    e.lat = op[2] ? 4'd3 : 4'd2;
    return e;
  endfunction

  function automatic logic [1:0] exp_alu_op(input logic [1:0] f);
    case (f)
      2'b00:   return 2'b00;
      2'b01:   return 2'b01;
      default: return 2'b10;
    endcase
  endfunction

  // Present a request and hold it until accepted; expectation is queued at accept
  task automatic send(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    int          t = 0;
    logic        done = 1'b0;
    logic        sub;
    logic [32:0] ls;
    logic [31:0] blo;
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    while (!done) begin
      @(negedge clk);
      if (req_ready) begin
        sub = (op[1:0] == 2'b11);
        blo = b[31:0];
        ls  = {1'b0, a[31:0]} + {1'b0, sub ? ~blo : blo} + {32'b0, sub};
        sb.push_back(ref_model(op, a, b));
        cur_op = op; cur_a = a; cur_b = b;
        lo_c = op[1] ? ls[32] : 1'b0;
        pass_idx = 0; in_flight = 1'b1; seen = 1'b0;
        accept_cyc = cyc + 1;
        done = 1'b1;
      end else if (++t > 200) begin
        checks++; errors++;
        $display("FAIL send_timeout: req_ready stayed low for op %b", op);
        done = 1'b1;
      end
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d responses outstanding", sb.size());
      sb.delete();
    end
    @(posedge clk); #1;
  endtask

  // Monitor: ALU port protocol each cycle, response compare against queue head
  exp_t m_e;
  always @(negedge clk) begin
    if (rst_n) begin
      if (!req_ready && !rsp_valid) begin
        if (in_flight) begin
          if (pass_idx == 0) begin
            chk("alu_a_lo", {32'b0, alu_a}, {32'b0, cur_a[31:0]});
            chk("alu_b_lo", {32'b0, alu_b}, {32'b0, cur_b[31:0]});
            chk("alu_cin_lo", {63'b0, alu_carryin}, {63'b0, cur_op[1:0] == 2'b11});
          end else begin
            chk("alu_a_hi", {32'b0, alu_a}, {32'b0, cur_a[63:32]});
            chk("alu_b_hi", {32'b0, alu_b}, {32'b0, cur_b[63:32]});
            chk("alu_cin_hi", {63'b0, alu_carryin}, {63'b0, lo_c});
          end
          chk("alu_operation", {62'b0, alu_operation}, {62'b0, exp_alu_op(cur_op[1:0])});
          chk("alu_binvert", {63'b0, alu_binvert}, {63'b0, cur_op[1:0] == 2'b11});
          pass_idx++;
        end
      end else begin
        chk("alu_idle_ab", {alu_a, alu_b}, 64'd0);
        chk("alu_idle_ctl", {60'b0, alu_operation, alu_binvert, alu_carryin}, 64'd0);
      end
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_rsp: result %h with empty scoreboard", rsp_result);
        end else begin
          m_e = sb[0];
          if (!seen) begin
            chk("latency", 64'(cyc - accept_cyc + 1), {60'b0, m_e.lat});
            chk("pass_count", 64'(pass_idx), cur_op[2] ? 64'd2 : 64'd1);
            seen = 1'b1;
          end
          chk("rsp_result", rsp_result, m_e.res);
          chk("rsp_carry", {63'b0, rsp_carry}, {63'b0, m_e.c});
          if (rsp_ready) begin
            void'(sb.pop_front());
            seen = 1'b0;
            in_flight = 1'b0;
          end
        end
      end
    end
  end

  // Random response backpressure when enabled
  always @(posedge clk) begin
    if (rand_bp) begin
      #1;
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
  end

  function automatic logic [63:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 64'd0;
      1:       return 64'hFFFF_FFFF_FFFF_FFFF;
      2:       return {32'd0, 32'hFFFF_FFFF};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    logic [63:0] ra, rb;
    req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;

    // Reset state
    #12;
    chk("rst_rsp_valid", {63'b0, rsp_valid}, 64'd0);
    chk("rst_rsp_result", rsp_result, 64'd0);
    chk("rst_rsp_carry", {63'b0, rsp_carry}, 64'd0);
    chk("rst_req_ready", {63'b0, req_ready}, 64'd1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed ops from the plan
    send(3'b010, 64'h0000_0000_FFFF_FFFF, 64'h1);
    send(3'b111, 64'h0000_0001_0000_0000, 64'h1);
    send(3'b100, 64'hF0F0_F0F0_FFFF_0000, 64'hFF00_FF00_0F0F_0F0F);
    send(3'b001, 64'h1234_0000_0000_00F0, 64'h0F);
    send(3'b011, 64'h0, 64'h0);
    send(3'b110, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1);
    drain();

    // Backpressure: response held, competing request must wait
    rsp_ready = 1'b0;
    send(3'b010, 64'd1, 64'd2);
    begin
      int t = 0;
      while (!rsp_valid && t < 20) begin @(negedge clk); t++; end
      chk("bp_rsp_valid", {63'b0, rsp_valid}, 64'd1);
    end
    fork
      send(3'b010, 64'd4, 64'd5);
      begin
        repeat (5) begin
          @(negedge clk);
          chk("bp_req_ready", {63'b0, req_ready}, 64'd0);
          chk("bp_result_held", rsp_result, 64'd3);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
      end
    join
    drain();

    // Reset during the HI pass of a wide ADD
    send(3'b110, 64'h0000_0001_0000_0005, 64'h0000_0002_0000_0003);
    @(posedge clk); #2;
    rst_n = 1'b0;
    in_flight = 1'b0; seen = 1'b0; sb.delete();
    #1;
    chk("midrst_rsp_valid", {63'b0, rsp_valid}, 64'd0);
    chk("midrst_rsp_result", rsp_result, 64'd0);
    chk("midrst_req_ready", {63'b0, req_ready}, 64'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(3'b011, 64'd5, 64'd7);
    drain();

    // Random traffic with random backpressure
    rand_bp = 1'b1;
    repeat (150) begin
      ra = pick_operand();
      rb = ($urandom_range(0, 7) == 0) ? ra : pick_operand();
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      send(3'($urandom_range(0, 7)), ra, rb);
    end
    drain();
    rand_bp = 1'b0;
    @(posedge clk); #2;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL global_timeout: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

endmodule
